// File: rtl/uart_rgb_pwm_if.sv
// uart_rgb_pwm_if -- byte stream bundle between a UART front end and uart_rgb_pwm.
//   rx_valid / rx_data : one-cycle strobe carrying a received byte (towards the core)
//   tx_valid / tx_data : response byte offered by the core
//   tx_ready           : sink accepts tx_data when tx_valid and tx_ready share an edge
// Modports: master = UART/sink side, slave = uart_rgb_pwm side.
interface uart_rgb_pwm_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output rx_valid,
    output rx_data,
    output tx_ready,
    input  tx_valid,
    input  tx_data
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  tx_ready,
    output tx_valid,
    output tx_data
  );
endinterface

// File: rtl/uart_rgb_pwm.sv
// uart_rgb_pwm -- ASCII command parser driving NUM_CH glitch-free PWM channels.
//   Command: channel digit '0'..'0'+NUM_CH-1 followed by PWM_W/4 hex digits (MSB first),
//   answered with 'K'. 'Z' in idle clears every duty ('K'); CR/LF in idle are ignored;
//   anything else answers '?' and bumps err_cnt. A partial command idle for TIMEOUT_CYC
//   cycles is silently dropped.
// Ports:
//   i_hw_clk   : clock, rising edge
//   i_reset    : synchronous active-high reset
//   io_bus     : uart_rgb_pwm_if.slave (rx strobe in, one-entry tx response buffer out)
//   o_pwm_out  : registered PWM outputs, active-high
//   o_err_cnt  : saturating count of rejected commands and dropped responses
// Build option: define UART_RGB_PWM_ECHO_EN to echo every byte except CR/LF ahead of its
//   command response; a second holding slot keeps echo-then-response ordering.
module uart_rgb_pwm #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned PWM_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 120000
) (
  input  logic              i_hw_clk,
  input  logic              i_reset,
  uart_rgb_pwm_if.slave     io_bus,
  output logic [NUM_CH-1:0] o_pwm_out,
  output logic [7:0]        o_err_cnt
);

  localparam int unsigned     NumDig  = PWM_W / 4;
  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0]      DigLast = 3'(NumDig - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      ChLast  = 8'(32'h30 + NUM_CH - 1);
  localparam logic [7:0]      AsciiCr = 8'h0D;
  localparam logic [7:0]      AsciiLf = 8'h0A;
  localparam logic [7:0]      AsciiZ  = 8'h5A;
  localparam logic [7:0]      AsciiK  = 8'h4B;
  localparam logic [7:0]      AsciiQ  = 8'h3F;

  typedef enum logic [0:0] {StIdle, StHex} state_e;

  // Parser state
  state_e           r_state;
  logic [2:0]       r_dig_cnt;
  logic [3:0]       r_ch;
  logic [PWM_W-1:0] r_acc;
  logic [TmoW-1:0]  r_tmo;

  // Duty and PWM state
  logic [PWM_W-1:0]  r_pend   [NUM_CH];
  logic [PWM_W-1:0]  r_active [NUM_CH];
  logic [PWM_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_pwm;

  // Response buffer and error counter
  logic       r_tx_valid;
  logic [7:0] r_tx_data;
  logic [7:0] r_err;

  logic             w_rx;
  logic [7:0]       w_byte;
  logic             w_is_hex;
  logic [3:0]       w_nib;
  logic             w_is_ch;
  logic [PWM_W-1:0] w_acc_next;
  logic             w_resp_q;
  logic [7:0]       w_resp_byte;
  logic             w_reject;
  logic             w_commit;
  logic             w_clear;
  logic             w_accept;
  logic             w_main_free;
  logic             w_tx_valid_nx;
  logic [7:0]       w_tx_data_nx;
  logic [1:0]       w_drops;
  logic [8:0]       w_err_sum;

  assign w_rx       = io_bus.rx_valid & ~i_reset;
  assign w_byte     = io_bus.rx_data;
  assign w_is_ch    = (w_byte >= 8'h30) && (w_byte <= ChLast);
  assign w_acc_next = (r_acc << 4) | PWM_W'(w_nib);

  // Hex digit decode, both letter cases
  always_comb begin
    w_is_hex = 1'b1;
    w_nib    = 4'h0;
    if (w_byte >= 8'h30 && w_byte <= 8'h39) begin
      w_nib = 4'(w_byte - 8'h30);
    end else if (w_byte >= 8'h41 && w_byte <= 8'h46) begin
      w_nib = 4'(w_byte - 8'h37);
    end else if (w_byte >= 8'h61 && w_byte <= 8'h66) begin
      w_nib = 4'(w_byte - 8'h57);
    end else begin
      w_is_hex = 1'b0;
    end
  end

  // Per-byte decision: which response (if any) this byte raises
  always_comb begin
    w_resp_q    = 1'b0;
    w_resp_byte = 8'h00;
    w_reject    = 1'b0;
    w_commit    = 1'b0;
    w_clear     = 1'b0;
    if (w_rx) begin
      unique case (r_state)
        StIdle: begin
          if (w_byte == AsciiCr || w_byte == AsciiLf) begin
            w_resp_q = 1'b0;
          end else if (w_byte == AsciiZ) begin
            w_clear     = 1'b1;
            w_resp_q    = 1'b1;
            w_resp_byte = AsciiK;
          end else if (!w_is_ch) begin
            w_reject = 1'b1;
          end
        end
        StHex: begin
          if (!w_is_hex) begin
            w_reject = 1'b1;
          end else if (r_dig_cnt == DigLast) begin
            w_commit    = 1'b1;
            w_resp_q    = 1'b1;
            w_resp_byte = AsciiK;
          end
        end
      endcase
    end
    if (w_reject) begin
      w_resp_q    = 1'b1;
      w_resp_byte = AsciiQ;
    end
  end

  // Parser FSM and pending duty registers
  always_ff @(posedge i_hw_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_dig_cnt <= 3'd0;
      r_ch      <= 4'd0;
      r_acc     <= '0;
      r_tmo     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_pend[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_rx && w_is_ch) begin
            r_state   <= StHex;
            r_ch      <= 4'(w_byte - 8'h30);
            r_dig_cnt <= 3'd0;
            r_acc     <= '0;
            r_tmo     <= '0;
          end
        end
        StHex: begin
          if (w_rx) begin
            r_tmo <= '0;
            if (!w_is_hex || w_commit) begin
              r_state <= StIdle;
            end else begin
              r_dig_cnt <= r_dig_cnt + 3'd1;
              r_acc     <= w_acc_next;
            end
          end else if (r_tmo == TmoLast) begin
            // Abandon the partial command silently
            r_state <= StIdle;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
      endcase
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_clear) begin
          r_pend[i] <= '0;
        end else if (w_commit && r_ch == 4'(i)) begin
          r_pend[i] <= w_acc_next;
        end
      end
    end
  end

  assign w_accept    = r_tx_valid & io_bus.tx_ready;
  assign w_main_free = ~r_tx_valid | w_accept;

`ifdef UART_RGB_PWM_ECHO_EN
  logic       r_hold_v;
  logic [7:0] r_hold_d;
  logic       w_echo_q;
  logic       w_hold_v_nx;
  logic [7:0] w_hold_d_nx;

  assign w_echo_q = w_rx && (w_byte != AsciiCr) && (w_byte != AsciiLf);

  always_comb begin
    w_tx_valid_nx = r_tx_valid & ~w_accept;
    w_tx_data_nx  = r_tx_data;
    w_hold_v_nx   = r_hold_v;
    w_hold_d_nx   = r_hold_d;
    w_drops       = 2'd0;
    if (r_hold_v && w_main_free) begin
      // Held response moves up first; anything arriving now finds no room
      w_tx_valid_nx = 1'b1;
      w_tx_data_nx  = r_hold_d;
      w_hold_v_nx   = 1'b0;
      w_drops       = 2'(w_echo_q) + 2'(w_resp_q);
    end else if (w_main_free) begin
      if (w_echo_q) begin
        w_tx_valid_nx = 1'b1;
        w_tx_data_nx  = w_byte;
        if (w_resp_q) begin
          w_hold_v_nx = 1'b1;
          w_hold_d_nx = w_resp_byte;
        end
      end else if (w_resp_q) begin
        w_tx_valid_nx = 1'b1;
        w_tx_data_nx  = w_resp_byte;
      end
    end else begin
      w_drops = 2'(w_echo_q) + 2'(w_resp_q);
    end
  end

  always_ff @(posedge i_hw_clk) begin
    if (i_reset) begin
      r_hold_v <= 1'b0;
      r_hold_d <= 8'h00;
    end else begin
      r_hold_v <= w_hold_v_nx;
      r_hold_d <= w_hold_d_nx;
    end
  end
`else
  always_comb begin
    w_tx_valid_nx = r_tx_valid & ~w_accept;
    w_tx_data_nx  = r_tx_data;
    w_drops       = 2'd0;
    if (w_resp_q) begin
      if (w_main_free) begin
        w_tx_valid_nx = 1'b1;
        w_tx_data_nx  = w_resp_byte;
      end else begin
        w_drops = 2'd1;
      end
    end
  end
`endif

  assign w_err_sum = {1'b0, r_err} + 9'(w_reject) + 9'(w_drops);

  // Response buffer and saturating error counter
  always_ff @(posedge i_hw_clk) begin
    if (i_reset) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_err      <= 8'h00;
    end else begin
      r_tx_valid <= w_tx_valid_nx;
      r_tx_data  <= w_tx_data_nx;
      r_err      <= (w_err_sum > 9'd255) ? 8'hFF : w_err_sum[7:0];
    end
  end

  // Free-running counter; active duties reload only as the counter wraps to 0
  always_ff @(posedge i_hw_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_pwm <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_active[i] <= '0;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (r_cnt == '1) begin
          r_active[i] <= r_pend[i];
        end
        r_pwm[i] <= (r_cnt < r_active[i]);
      end
    end
  end

  assign io_bus.tx_valid = r_tx_valid;
  assign io_bus.tx_data  = r_tx_data;
  assign o_pwm_out       = r_pwm;
  assign o_err_cnt       = r_err;

endmodule

// File: doc/uart_rgb_pwm.md
UART_RGB_PWM -- requirements
Module: uart_rgb_pwm

Interface
REQ-001 Parameter NUM_CH, default 3: number of PWM output channels, 1..10.
REQ-002 Parameter PWM_W, default 8: duty/counter width in bits, one of 4, 8, 12, 16.
REQ-003 Parameter TIMEOUT_CYC, default 120000: idle cycles after which a partial command is abandoned, at least 2.
REQ-004 hw_clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
REQ-007 rx_data  in  8  received byte.
REQ-008 tx_valid  out  1  response byte available.
REQ-009 tx_data  out  8  response byte; stable while tx_valid=1 and tx_ready=0.
REQ-010 tx_ready  in  1  sink accepts tx_data when tx_valid=1 and tx_ready=1 on the same edge.
REQ-011 pwm_out  out  NUM_CH  per-channel PWM output, active-high.
REQ-012 err_cnt  out  8  saturating count of rejected commands and dropped responses.

Function
REQ-013 The command format is ASCII: one channel digit '0'..('0'+NUM_CH-1), then D=PWM_W/4 hex digits ('0'-'9', 'A'-'F', 'a'-'f'), MSB first.
REQ-014 Parser states: IDLE -> HEX on a valid channel digit (digit counter cleared) -> HEX until D digits are received -> commit -> IDLE.
REQ-015 Commit writes the assembled value to pending_duty[ch] and queues response 'K' (0x4B).
REQ-016 In IDLE, byte 'Z' sets every pending_duty to 0 and queues 'K'.
REQ-017 In IDLE, CR (0x0D) and LF (0x0A) are ignored without a response.
REQ-018 Any other byte in IDLE, or a non-hex byte in HEX, queues '?' (0x3F), increments err_cnt and returns to IDLE; a partial value is discarded.
REQ-019 In HEX, TIMEOUT_CYC cycles without rx_valid return the parser to IDLE silently, with no response and no err_cnt increment.
REQ-020 Each received byte is consumed in the rx_valid cycle, so back-to-back strobes on consecutive cycles are all processed.
REQ-021 The response buffer holds one entry; tx_valid rises the cycle after the response is queued.
REQ-022 If a response is queued while the buffer is full and not being accepted that cycle, the new response is dropped and err_cnt increments.
REQ-023 If the buffer is accepted and a new response is queued in the same cycle, the new one is loaded.
REQ-024 The PWM counter is free-running PWM_W bits and wraps from 2^PWM_W-1 to 0.
REQ-025 pwm_out[i] is registered and equals (counter < active_duty[i]): duty 0 gives constant low; duty all-ones gives high for 2^PWM_W-1 of 2^PWM_W cycles.
REQ-026 active_duty copies pending_duty only on the cycle the counter wraps to 0, so there are no glitches mid-period.
REQ-027 A commit in the same cycle as the wrap takes effect at the following wrap.
REQ-028 err_cnt saturates at 255 and never wraps.

Reset
REQ-029 On reset: parser to IDLE, digit counter 0, PWM counter 0, all pending and active duty 0, pwm_out 0, tx_valid 0, tx_data 0x00, err_cnt 0, timeout counter 0.
REQ-030 Reset asserted mid-command or with a response pending discards both; there is no response after reset release.
REQ-031 rx_valid is ignored in any cycle where reset=1.

Configuration
REQ-032 Macro UART_RGB_PWM_ECHO_EN defined: every accepted byte (except CR/LF) is echoed through the response buffer before its command response. The echo takes the buffer when it is free. When echo and 'K' or '?' arise from the same byte, the echo goes first and the second response is held until the echo is accepted. This two-entry ordering is the only buffer growth permitted.
REQ-033 UART_RGB_PWM_ECHO_EN undefined: no echo; behaviour is exactly REQ-013 to REQ-031.

Verification (NUM_CH=3, PWM_W=8, TIMEOUT_CYC=100, echo off unless stated)
REQ-034 Send "1","8","0", tx_ready=1 -> tx 'K'; after the next wrap, pwm_out[1] is high for exactly 128 of 256 cycles; the other channels stay low.
REQ-035 Send "0","F","F" then "Z" -> two 'K'; pwm_out[0] is high 255 of 256 cycles, then constant low from the wrap after 'Z'.
REQ-036 Send "3" -> '?' and err_cnt=1; send "2","G" -> '?' and err_cnt=2; duties are unchanged.
REQ-037 Send "2","4", wait 150 cycles, send "0","1","0" -> only one 'K'; channel 0 duty is 0x10 and channel 2 stays 0.
REQ-038 With tx_ready=0, send "Z" twice -> tx_data holds 'K', the second response is dropped, and err_cnt=1.
REQ-039 With ECHO_EN and tx_ready=1, send "1","4","0" -> tx sequence '1','4','0','K'.
